if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and the decode stage.
//  - Buffers {Inst, PCAdd2} pairs from fetch so i-cache latency and decode stalls decouple.
//  - Presents the oldest entry to decode, or the NOP 16'h0800 when nothing is valid.
//  - Discards all contents on a branch redirect (flush).
// PARAMETERS
//  DEPTH  2   entries; power of two, >=2
//  IW     16  instruction width
//  PW     16  PC+2 width
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  rst         in   1       synchronous, active-low reset (0 = reset)
//  flush       in   1       branch redirect; drops all entries, synchronous
//  in_valid    in   1       fetch offers {in_inst, in_pcadd2}
//  in_inst     in   IW      fetched instruction
//  in_pcadd2   in   PW      PC+2 of in_inst
//  in_ready    out  1       queue can accept; push = in_valid & in_ready
//  out_valid   out  1       out_inst/out_pcadd2 hold a real entry
//  out_inst    out  IW      head instruction; NOP 16'h0800 when !out_valid
//  out_pcadd2  out  PW      head PC+2; 16'h0000 when !out_valid
//  out_ready   in   1       decode consumes; pop = out_valid & out_ready
//  count       out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Storage: circular buffer with rd_ptr and wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH).
//  - count is a separate register with range 0..DEPTH.
//  - Reset (rst==0 at posedge): ptrs=0, count=0. Next cycle: out_valid=0, out_inst=16'h0800,
//    out_pcadd2=0, in_ready=1. Any push/pop in the reset cycle is ignored.
//  - in_ready = (count != DEPTH). Depends only on state, never on out_ready
//    (no combinational ready path from decode back to fetch).
//  - out_valid = (count != 0) & ~flush & rst. Decode sees NOP in flush and reset cycles.
//  - Push: write entry at wr_ptr; wr_ptr++ (wraps); count++.
//  - Pop: rd_ptr++ (wraps); count--.
//  - Push and pop in the same cycle: both pointers advance, count unchanged.
//    Legal at full (pop frees the slot the push writes next cycle? no) -> at full
//    in_ready=0, so only the pop occurs.
//  - Push while empty: entry visible on out_* the next cycle (latency 1) unless bypass is enabled.
//  - Priority: reset > flush > push/pop.
//    Flush: ptrs=0, count=0; a push in the flush cycle is discarded.
//    in_ready keeps its state-based value during flush.
//  - Flush and reset mid-stream are equivalent; no partial entries survive.
//  - Storage is not cleared on reset/flush; out_* are masked by out_valid instead.
//  - in_valid with in_ready=0 is ordinary backpressure: fetch must hold its PC; no error is raised.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//  - When count==0, in_valid=1, flush=0 and rst=1: out_valid=1 and out_* = in_* combinationally.
//  - If out_ready is also 1, the entry is consumed without being written: ptrs and count unchanged.
//  - Otherwise it is pushed normally.
//  - Zero-latency empty path.
//  IFQ_BYPASS_EN undefined:
//  - Strict 1-cycle latency.
//  - No combinational path from in_* to out_*.
// STRUCTURE
//  - Shared include pipe_defs.vh: `NOP_INST 16'h0800, `INST_W 16, `PC_W 16.
//    Fetch and decode stages use the same include.
//  - One sub-module: ifq_regfile (DEPTH x (IW+PW) flop array; 1 write port, 1 async read port,
//    no reset on data).
//  - Pointer, count, and handshake logic live in if_id_queue.
// TESTING
//  1. Reset: rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_inst=16'h0800, count=0,
//     in_ready=1 after reset.
//  2. Fill and drain: push 0x1111/0x0002, 0x2222/0x0004 with out_ready=0 -> count=2, in_ready=0.
//     A third in_valid is ignored. Then out_ready=1 -> 0x1111, then 0x2222 in order, count=0.
//  3. Simultaneous: count=1 (0xAAAA), push 0xBBBB with out_ready=1 -> count stays 1,
//     head becomes 0xBBBB next cycle.
//  4. Flush: count=2, flush=1 with in_valid=1 (0xCCCC) -> same cycle out_valid=0/NOP.
//     Next cycle count=0 and 0xCCCC is absent.
//  5. Wrap: stream 8 instructions 0x0101..0x0808 with random out_ready -> exact in-order output,
//     no drops or duplicates, ptrs wrap cleanly.
//  6. Build with and without IFQ_BYPASS_EN, empty queue, push 0x3333 with out_ready=1:
//     - defined: out_inst=0x3333 the same cycle, count stays 0.
//     - undefined: out_inst appears the next cycle.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue: pipeline widths,
// the decode NOP encoding and the per-cycle queue operation type.
package if_id_queue_pkg;

   localparam int unsigned INST_W = 16;
   localparam int unsigned PC_W   = 16;

   localparam logic [INST_W-1:0] NOP_INST = 16'h0800;

   // What the queue storage does in a given cycle once handshakes are resolved.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

   function automatic q_op_e make_op(input logic push, input logic pop);
      return q_op_e'({push, pop});
   endfunction

endpackage : if_id_queue_pkg

// File: rtl/ifq_regfile.sv
// Entry storage for the instruction queue: DEPTH x W flops, one synchronous
// write port and one asynchronous read port. Data carries no reset.
module ifq_regfile #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; readers mask stale data with a valid flag.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : ifq_regfile

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: circular buffer of {inst, pcadd2}
// pairs with flush. Optional zero-latency empty path under IFQ_BYPASS_EN.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned IW    = INST_W,
   parameter int unsigned PW    = PC_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [IW-1:0]          in_inst,
   input  logic [PW-1:0]          in_pcadd2,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [IW-1:0]          out_inst,
   output logic [PW-1:0]          out_pcadd2,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = IW + PW;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] occ;

   logic          empty;
   logic          stored_valid;
   logic          bypass;
   logic          push;
   logic          pop;
   q_op_e         op;
   logic [EW-1:0] head;

   assign empty    = (occ == '0);
   assign in_ready = (occ != FULL);
   assign count    = occ;

   // A real stored entry is only presented outside flush and reset cycles.
   assign stored_valid = ~empty & ~flush & rst;

`ifdef IFQ_BYPASS_EN
   assign bypass = empty & in_valid & ~flush & rst;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry consumed in the same cycle never touches storage.
   assign push = in_valid & in_ready & ~(bypass & out_ready);
   assign pop  = stored_valid & out_ready;
   assign op   = make_op(push, pop);

   ifq_regfile #(
      .DEPTH (DEPTH),
      .W     (EW),
      .AW    (AW)
   ) u_regfile (
      .clk   (clk),
      .we    (push & rst & ~flush),
      .waddr (wr_ptr),
      .wdata ({in_inst, in_pcadd2}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Reset outranks flush, which outranks any handshake in the same cycle.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         case (op)
            OP_PUSH: begin
               wr_ptr <= wr_ptr + AW'(1);
               occ    <= occ + CW'(1);
            end
            OP_POP: begin
               rd_ptr <= rd_ptr + AW'(1);
               occ    <= occ - CW'(1);
            end
            OP_BOTH: begin
               wr_ptr <= wr_ptr + AW'(1);
               rd_ptr <= rd_ptr + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output gets a default first so no latch is inferred on the idle path.
   always_comb begin
      out_valid  = 1'b0;
      out_inst   = IW'(NOP_INST);
      out_pcadd2 = '0;
      if (stored_valid) begin
         out_valid  = 1'b1;
         out_inst   = head[EW-1:PW];
         out_pcadd2 = head[PW-1:0];
      end else if (bypass) begin
         out_valid  = 1'b1;
         out_inst   = in_inst;
         out_pcadd2 = in_pcadd2;
      end
   end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model;
// build with +define+IFQ_BYPASS_EN to exercise the bypass variant.
module tb_if_id_queue;

   localparam int DEPTH = 2;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_inst, in_pcadd2, out_inst, out_pcadd2;
   logic [1:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mq[$];
   logic [31:0] got[$];
   bit          last_push;

   always #5 clk = ~clk;

   if_id_queue #(.DEPTH(DEPTH), .IW(16), .PW(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_inst(in_inst), .in_pcadd2(in_pcadd2), .in_ready(in_ready),
      .out_valid(out_valid), .out_inst(out_inst), .out_pcadd2(out_pcadd2),
      .out_ready(out_ready), .count(count)
   );

   // ---------------- reference model ----------------
   function automatic bit e_valid();
      return rst && !flush && (mq.size() != 0 || (BYP && in_valid));
   endfunction

   function automatic logic [15:0] e_inst();
      if (!e_valid()) return 16'h0800;
      return (mq.size() != 0) ? mq[0][31:16] : in_inst;
   endfunction

   function automatic logic [15:0] e_pc();
      if (!e_valid()) return 16'h0000;
      return (mq.size() != 0) ? mq[0][15:0] : in_pcadd2;
   endfunction

   task automatic model_step();
      bit do_push, do_pop;
      last_push = 1'b0;
      if (!rst || flush) begin
         mq.delete();
      end else if (BYP && mq.size() == 0 && in_valid && out_ready) begin
         got.push_back({in_inst, in_pcadd2});
      end else begin
         do_pop  = (mq.size() != 0) && out_ready;
         do_push = in_valid && (mq.size() < DEPTH);
         if (do_pop) got.push_back(mq.pop_front());
         if (do_push) mq.push_back({in_inst, in_pcadd2});
         last_push = do_push;
      end
   endtask

   // Drive one cycle's inputs, then let them settle before sampling.
   task automatic apply(input logic r, input logic f, input logic iv,
                        input logic [15:0] inst, input logic [15:0] pc, input logic ordy);
      rst = r; flush = f; in_valid = iv; in_inst = inst; in_pcadd2 = pc; out_ready = ordy;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0002, 1'b0);
      tick();
      apply(1'b0, 1'b0, 1'b1, 16'h5678, 16'h0004, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_cycle_valid: got %b want 0", out_valid);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (out_inst !== 16'h0800) begin
         n_bad++; $display("FAIL reset_inst: got %h want 0800", out_inst);
      end
      n_cmp++;
      if (out_pcadd2 !== 16'h0000) begin
         n_bad++; $display("FAIL reset_pc: got %h want 0000", out_pcadd2);
      end
      n_cmp++;
      if (count !== 2'd0) begin
         n_bad++; $display("FAIL reset_count: got %0d want 0", count);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_fill_drain();
      apply(1'b1, 1'b0, 1'b1, 16'h1111, 16'h0002, 1'b0);
      tick();
      apply(1'b1, 1'b0, 1'b1, 16'h2222, 16'h0004, 1'b0);
      tick();
      apply(1'b1, 1'b0, 1'b1, 16'h3333, 16'h0006, 1'b0);
      n_cmp++;
      if (count !== 2'd2) begin
         n_bad++; $display("FAIL full_count: got %0d want 2", count);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++;
      if (count !== 2'd2) begin
         n_bad++; $display("FAIL full_ignore_count: got %0d want 2", count);
      end
      n_cmp++;
      if (out_inst !== 16'h1111 || out_pcadd2 !== 16'h0002) begin
         n_bad++; $display("FAIL drain_first: got %h/%h want 1111/0002", out_inst, out_pcadd2);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++;
      if (out_inst !== 16'h2222 || out_pcadd2 !== 16'h0004) begin
         n_bad++; $display("FAIL drain_second: got %h/%h want 2222/0004", out_inst, out_pcadd2);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      n_cmp++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         n_bad++; $display("FAIL drained: got count %0d valid %b want 0 0", count, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      apply(1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h0010, 1'b0);
      tick();
      apply(1'b1, 1'b0, 1'b1, 16'hBBBB, 16'h0012, 1'b1);
      n_cmp++;
      if (out_inst !== 16'hAAAA || count !== 2'd1) begin
         n_bad++; $display("FAIL b2b_before: got %h cnt %0d want AAAA cnt 1", out_inst, count);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      n_cmp++;
      if (out_inst !== 16'hBBBB || count !== 2'd1) begin
         n_bad++; $display("FAIL b2b_after: got %h cnt %0d want BBBB cnt 1", out_inst, count);
      end
      // Leave the queue empty for the following scenario.
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      tick();
   endtask

   task automatic test_flush();
      apply(1'b1, 1'b0, 1'b1, 16'h4444, 16'h0020, 1'b0);
      tick();
      apply(1'b1, 1'b0, 1'b1, 16'h5555, 16'h0022, 1'b0);
      tick();
      apply(1'b1, 1'b1, 1'b1, 16'hCCCC, 16'h0024, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0 || out_inst !== 16'h0800) begin
         n_bad++; $display("FAIL flush_cycle: got %b/%h want 0/0800", out_valid, out_inst);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      n_cmp++;
      if (count !== 2'd0 || out_valid !== 1'b0 || out_inst === 16'hCCCC) begin
         n_bad++; $display("FAIL flush_after: got cnt %0d valid %b inst %h want 0 0 0800", count, out_valid, out_inst);
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_e;
      int          idx = 0;
      int          cyc = 0;
      got.delete();
      while (got.size() < 8 && cyc < 300) begin
         apply(1'b1, 1'b0, idx < 8, {2{8'(idx + 1)}}, 16'(2 * (idx + 1)), 1'($urandom_range(0, 1)));
         n_cmp++;
         if (out_valid !== e_valid() || out_inst !== e_inst()) begin
            n_bad++; $display("FAIL wrap_head cyc %0d: got %b/%h want %b/%h", cyc, out_valid, out_inst, e_valid(), e_inst());
         end
         tick();
         if (last_push || (BYP && idx < 8 && got.size() > 0 && got[$][31:16] == {2{8'(idx + 1)}})) idx++;
         cyc++;
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_bad++; $display("FAIL wrap_timeout: got %0d entries want 8", got.size());
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         exp_e = {{2{8'(i + 1)}}, 16'(2 * (i + 1))};
         n_cmp++;
         if (got[i] !== exp_e) begin
            n_bad++; $display("FAIL wrap_order %0d: got %h want %h", i, got[i], exp_e);
         end
      end
   endtask

   task automatic test_bypass();
      apply(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      tick();
      apply(1'b1, 1'b0, 1'b1, 16'h3333, 16'h0030, 1'b1);
      n_cmp++;
      if (out_valid !== BYP || out_inst !== (BYP ? 16'h3333 : 16'h0800)) begin
         n_bad++; $display("FAIL bypass_same_cycle: got %b/%h want %b/%h", out_valid, out_inst, BYP, BYP ? 16'h3333 : 16'h0800);
      end
      tick();
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      n_cmp++;
      if (count !== (BYP ? 2'd0 : 2'd1)) begin
         n_bad++; $display("FAIL bypass_count: got %0d want %0d", count, BYP ? 0 : 1);
      end
      n_cmp++;
      if (out_inst !== (BYP ? 16'h0800 : 16'h3333)) begin
         n_bad++; $display("FAIL bypass_next: got %h want %h", out_inst, BYP ? 16'h0800 : 16'h3333);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         n_cmp++;
         if (out_valid !== e_valid() || out_inst !== e_inst() || out_pcadd2 !== e_pc()) begin
            n_bad++; $display("FAIL rand_out cyc %0d: got %b/%h/%h want %b/%h/%h", c, out_valid, out_inst, out_pcadd2, e_valid(), e_inst(), e_pc());
         end
         n_cmp++;
         if (count !== 2'(mq.size()) || in_ready !== (mq.size() != DEPTH)) begin
            n_bad++; $display("FAIL rand_state cyc %0d: got cnt %0d rdy %b want %0d %b", c, count, in_ready, mq.size(), mq.size() != DEPTH);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_bypass();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_if_id_queue
